// File: rtl/ascon_host_ctrl.sv
// Byte-serial host controller for the Ascon core.
// Loads key/nonce/data byte by byte, fires a one-cycle start, waits for
// completion under a timeout, then streams the 320-bit state back out.
module ascon_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    mode_in,
  input  logic          go,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [127:0]  reg0_128b,
  output logic [127:0]  reg1_128b,
  output logic [127:0]  reg2_128b,
  output logic [2:0]    operation_mode,
  output logic          operation_ready,
  input  logic          core_done,
  input  logic [63:0]   S_0_reg,
  input  logic [63:0]   S_1_reg,
  input  logic [63:0]   S_2_reg,
  input  logic [63:0]   S_3_reg,
  input  logic [63:0]   S_4_reg,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          error
);

  typedef enum logic [2:0] {
    ST_LOAD, ST_ARMED, ST_START, ST_RUN, ST_DRAIN, ST_ERR
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [5:0]     r_idx;
  logic [7:0]     r_cnt;
  logic [127:0]   r_reg0;
  logic [127:0]   r_reg1;
  logic [127:0]   r_reg2;
  logic [2:0]     r_mode;
  logic [319:0]   r_snap;
  logic           w_mode_ok;
  logic           w_timeout;

  assign w_mode_ok = (mode_in >= 3'd1) && (mode_in <= 3'd5);
  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  assign reg0_128b      = r_reg0;
  assign reg1_128b      = r_reg1;
  assign reg2_128b      = r_reg2;
  assign operation_mode = r_mode;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded outputs; abort overrides everything
  always_comb begin
    w_next          = r_state;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    operation_ready = 1'b0;
    busy            = 1'b0;
    error           = 1'b0;
    out_data        = '0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_idx == 6'd47) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (go) w_next = w_mode_ok ? ST_START : ST_ERR;
      end
      ST_START: begin
        operation_ready = 1'b1;
        busy            = 1'b1;
        w_next          = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (core_done)      w_next = ST_DRAIN;
        else if (w_timeout) w_next = ST_ERR;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_snap[{6'd39 - r_idx, 3'b000} +: 8];
        if (out_ready && r_idx == 6'd39) w_next = ST_LOAD;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: w_next = ST_LOAD;
    endcase
    if (abort) w_next = ST_LOAD;
  end

  // Datapath: byte index, run counter, operands, mode and snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_reg0 <= '0;
      r_reg1 <= '0;
      r_reg2 <= '0;
      r_mode <= '0;
      r_snap <= '0;
    end else if (abort) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            case (r_idx[5:4])
              2'd0:    r_reg0[{4'd15 - r_idx[3:0], 3'b000} +: 8] <= in_data;
              2'd1:    r_reg1[{4'd15 - r_idx[3:0], 3'b000} +: 8] <= in_data;
              2'd2:    r_reg2[{4'd15 - r_idx[3:0], 3'b000} +: 8] <= in_data;
              default: ;
            endcase
            r_idx <= (r_idx == 6'd47) ? '0 : r_idx + 6'd1;
          end
        end
        ST_ARMED: begin
          if (go && w_mode_ok) r_mode <= mode_in;
        end
        ST_START: r_cnt <= '0;
        ST_RUN: begin
          if (core_done) r_snap <= {S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg};
          else           r_cnt  <= r_cnt + 8'd1;
        end
        ST_DRAIN: begin
          if (out_ready) r_idx <= (r_idx == 6'd39) ? '0 : r_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ascon_host_ctrl.md
# ascon_host_ctrl

Byte-serial host controller that sequences the Ascon core from a narrow 8-bit pin interface. It loads the three 128-bit operand registers (key/nonce/data) byte by byte and latches the operation mode. It then issues a single-cycle start to the core and waits for completion under a timeout. On completion it snapshots the 320-bit state and streams it back out as bytes. It sits between the chip top-level pins and the Ascon core instance.

## Interface

**Parameters**

- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in RUN before an error is raised. Must be ≥ 1. The counter is 8 bits wide, so the maximum value is 255.

**Ports**

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mode_in`  in  3  requested mode: 1 enc, 2 dec, 3 hash, 4 xof, 5 cxof. Codes 0, 6 and 7 are invalid.
- `go`  in  1  run request; honoured only in ARMED.
- `abort`  in  1  synchronous abort; highest priority, effective in every state.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  input byte accepted when `in_valid && in_ready`.
- `reg0_128b`, `reg1_128b`, `reg2_128b`  out  128 each  operand registers driven to the core.
- `operation_mode`  out  3  latched mode driven to the core.
- `operation_ready`  out  1  one-cycle start pulse to the core.
- `core_done`  in  1  completion pulse from the core.
- `S_0_reg` … `S_4_reg`  in  64 each  core state words.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  8  output byte.
- `out_ready`  in  1  output byte consumed when `out_valid && out_ready`.
- `busy`  out  1  high in START or RUN.
- `error`  out  1  high in ERR.

## Operation

**States:** LOAD, ARMED, START, RUN, DRAIN, ERR.

**Reset values**
- State is LOAD.
- Byte index = 0, timeout counter = 0.
- All operand registers, `operation_mode` and the snapshot are 0.
- Outputs `out_valid = 0`, `operation_ready = 0`, `busy = 0`, `error = 0`, `out_data = 0`.
- `in_ready = 1` immediately after reset.

**LOAD**
- `in_ready = 1`.
- Each accepted byte k (6-bit index, 0..47) is written in place:
  - k 0..15 → `reg0_128b[127-8k -: 8]`, i.e. byte 0 → `[127:120]`, byte 15 → `[7:0]`.
  - k 16..31 → `reg1_128b`, same MSB-first ordering.
  - k 32..47 → `reg2_128b`, same MSB-first ordering.
- Bytes not rewritten keep their previous values.
- Acceptance of byte 47 → ARMED, index reset to 0.
- `go` is ignored in LOAD.

**ARMED**
- `in_ready = 0`.
- On `go`:
  - valid `mode_in` → latch it into `operation_mode`, go to START;
  - invalid `mode_in` (0/6/7) → ERR, `operation_mode` unchanged.

**START**
- `operation_ready = 1` for exactly this one cycle.
- Timeout counter cleared.
- Unconditionally → RUN on the next edge, unless `abort`.

**RUN**
- Counter increments each cycle.
- `core_done` sampled high → capture `{S_0_reg..S_4_reg}` into the 320-bit snapshot and go to DRAIN.
- Otherwise, counter == `TIMEOUT_CYCLES-1` → ERR.
- If `core_done` arrives in the same cycle as the timeout, DRAIN wins.

**DRAIN**
- `out_valid = 1`.
- `out_data` = snapshot byte j, MSB-first: j = 0 → `S_0[63:56]`, j = 7 → `S_0[7:0]`, j = 8 → `S_1[63:56]`, …, j = 39 → `S_4[7:0]`.
- Index advances only on a transfer. `out_data` is held stable while `out_ready` is low.
- Transfer of byte 39 → LOAD, index 0. Operand registers are retained.

**ERR**
- `error = 1`, all handshakes deasserted.
- Exits only on `abort`.

**abort**
- From any state: next state LOAD, index 0, counter 0.
- Operand registers, `operation_mode` and the snapshot are retained.
- `operation_ready` is a pure decode of START, so an abort sampled during START still leaves that pulse issued.

**Other rules**
- `core_done` is ignored outside RUN.
- `in_valid` is ignored outside LOAD.

## Timing

- All state is registered. `in_ready`, `out_valid`, `operation_ready`, `busy` and `error` are decoded from the state only, with no combinational path from any input.
- `out_data` comes from a registered index mux.
- Byte 47 accepted at edge N → ARMED from N+1. `go` sampled at edge M → START during cycle M..M+1, then RUN from M+1.
- `core_done` sampled at edge P → `out_valid = 1` with byte 0 from P.
- Minimum DRAIN duration is 40 cycles, at one byte per cycle with `out_ready` held high.
- Minimum LOAD duration is 48 cycles.
- Maximum RUN duration is `TIMEOUT_CYCLES` cycles.
- Asynchronous reset mid-transfer returns all values to reset immediately. No partial byte is retained.

## Test plan

- **Load ordering:** reset, then load bytes 0x00..0x2F with `in_valid` held high. Expect `reg0 = 0x000102…0F`, `reg1 = 0x1011…1F`, `reg2 = 0x2021…2F`, and `in_ready` low after the 48th byte.
- **Run and drain:** ARMED, `mode_in = 1`, `go`. Expect `operation_ready` high for exactly 1 cycle and `operation_mode = 1`. Then pulse `core_done` with `S_0 = 0x0123456789ABCDEF` and `S_4 = 0xFEDCBA9876543210`. Expect the first 8 output bytes 01 23 45 67 89 AB CD EF, the last byte 0x10, and return to LOAD after 40 transfers.
- **Backpressure:** in DRAIN, toggle `out_ready` 1/0 randomly. Expect `out_data` stable while stalled, no byte skipped or duplicated, and exactly 40 transfers.
- **Invalid mode:** `go` with `mode_in = 6`. Expect `error = 1`, `operation_ready` never asserted, `operation_mode` unchanged. Then `abort` → `error = 0` and `in_ready = 1`.
- **Timeout:** `TIMEOUT_CYCLES = 4`, no `core_done`. Expect ERR after exactly 4 RUN cycles. Then repeat with `core_done` on the 4th RUN cycle → expect DRAIN, not ERR.
- **Abort mid-load / mid-drain:** abort after 20 input bytes, reload 48 bytes, and expect correct operands. Abort after 5 output bytes, and expect `out_valid` low next cycle with the index back at 0.
